// File: rtl/me_pkg.sv
// me_pkg: shared widths, selector state encoding and result-word field helpers for the SAD result path.
package me_pkg;
  localparam int SAD_W  = 13;
  localparam int ADDR_W = 8;
  localparam int RES_W  = SAD_W + ADDR_W;
  typedef enum logic [1:0] {IDLE, SKIP, SEARCH, DONE} sel_state_t;
  function automatic logic [SAD_W-1:0] sad_of(input logic [RES_W-1:0] r);
    return r[RES_W-1:ADDR_W];
  endfunction
  function automatic logic [ADDR_W-1:0] addr_of(input logic [RES_W-1:0] r);
    return r[ADDR_W-1:0];
  endfunction
endpackage

// File: rtl/sad_min_select_if.sv
// sad_min_select_if: result-stream input and motion-vector output bundle of the minimum selector.
interface sad_min_select_if;
  import me_pkg::*;
  logic              start;
  logic              in_valid;
  logic [RES_W-1:0]  res_in;
  logic              busy;
  logic              done;
  logic [SAD_W-1:0]  best_sad;
  logic [ADDR_W-1:0] best_addr;
  logic [6:0]        cand_cnt;
  modport master (output start, in_valid, res_in, input busy, done, best_sad, best_addr, cand_cnt);
  modport slave  (input start, in_valid, res_in, output busy, done, best_sad, best_addr, cand_cnt);
endinterface

// File: rtl/sad_cmp_reg.sv
// sad_cmp_reg: running-minimum register; the first word after clear is always captured, later ones only when strictly smaller.
module sad_cmp_reg
  import me_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [SAD_W-1:0]  sad_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [SAD_W-1:0]  nxt_min_o,
  output logic [ADDR_W-1:0] nxt_addr_o
);
  logic              first_q, first_d, take;
  logic [SAD_W-1:0]  min_q, min_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  always_comb begin
    take    = en_i && (first_q || sad_i < min_q);
    min_d   = clr_i ? '1 : take ? sad_i : min_q;
    addr_d  = clr_i ? '0 : take ? addr_i : addr_q;
    first_d = clr_i ? 1'b1 : en_i ? 1'b0 : first_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q   <= '1;
      addr_q  <= '0;
      first_q <= 1'b1;
    end else begin
      min_q   <= min_d;
      addr_q  <= addr_d;
      first_q <= first_d;
    end
  end
  assign nxt_min_o  = min_d;
  assign nxt_addr_o = addr_d;
endmodule

// File: rtl/sad_min_select.sv
// sad_min_select: drops SAD pipeline warm-up words, tracks the minimum over NUM_CAND candidates and reports it with a done pulse.
// Define SAD_MIN_EARLY_TERM_EN to end a search as soon as a SAD below EARLY_THRESH is accepted.
module sad_min_select
  import me_pkg::*;
#(
  parameter int NUM_CAND = 64,
  parameter int SKIP_CYC = 5
`ifdef SAD_MIN_EARLY_TERM_EN
  , parameter int EARLY_THRESH = 64
`endif
)(
  input logic        clk,
  input logic        rst,
  sad_min_select_if.slave sel_if
);
  localparam int SK_W = $clog2(SKIP_CYC + 2);
  localparam logic [SK_W-1:0] SKN  = SK_W'(SKIP_CYC);
  localparam logic [6:0]      LAST = 7'(NUM_CAND - 1);
  sel_state_t        state_q, state_d;
  logic [SK_W-1:0]   skip_q, skip_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [SAD_W-1:0]  best_sad_q, best_sad_d, nxt_min, sad;
  logic [ADDR_W-1:0] best_addr_q, best_addr_d, nxt_addr, addr;
  logic              acc, last;
  assign sad  = sad_of(sel_if.res_in);
  assign addr = addr_of(sel_if.res_in);
  assign acc  = state_q == SEARCH && sel_if.in_valid && !sel_if.start;
`ifdef SAD_MIN_EARLY_TERM_EN
  assign last = acc && (cnt_q == LAST || sad < SAD_W'(EARLY_THRESH));
`else
  assign last = acc && cnt_q == LAST;
`endif
  sad_cmp_reg u_cmp (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (sel_if.start),
    .en_i      (acc),
    .sad_i     (sad),
    .addr_i    (addr),
    .nxt_min_o (nxt_min),
    .nxt_addr_o(nxt_addr)
  );
  // start outranks everything; a word arriving with it is the first warm-up word
  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    cnt_d       = cnt_q;
    best_sad_d  = best_sad_q;
    best_addr_d = best_addr_q;
    if (sel_if.start) begin
      skip_d  = SK_W'(sel_if.in_valid);
      cnt_d   = '0;
      state_d = (SK_W'(sel_if.in_valid) >= SKN) ? SEARCH : SKIP;
    end else if (state_q == SKIP && sel_if.in_valid) begin
      skip_d  = skip_q + 1'b1;
      state_d = (skip_q + 1'b1 == SKN) ? SEARCH : SKIP;
    end else if (acc) begin
      cnt_d       = cnt_q + 7'd1;
      state_d     = last ? DONE : SEARCH;
      best_sad_d  = last ? nxt_min : best_sad_q;
      best_addr_d = last ? nxt_addr : best_addr_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      skip_q      <= '0;
      cnt_q       <= '0;
      best_sad_q  <= '1;
      best_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      cnt_q       <= cnt_d;
      best_sad_q  <= best_sad_d;
      best_addr_q <= best_addr_d;
    end
  end
  assign sel_if.busy      = state_q == SKIP || state_q == SEARCH;
  assign sel_if.done      = state_q == DONE;
  assign sel_if.best_sad  = best_sad_q;
  assign sel_if.best_addr = best_addr_q;
  assign sel_if.cand_cnt  = cnt_q;
endmodule
